// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage:
//               fetch FSM state, data widths, default PC / NOP values and the
//               prefetch FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 16'h0000;
  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT  = 16'h0000;

  // FETCH issues sequential requests; DISCARD waits out a request that a
  // redirect made stale and throws its data away.
  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus_two;
  } fifo_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Prefetch FIFO between the instruction-memory port and the
//               fetch/decode pipeline register. DEPTH must be a power of two
//               (>= 2) so the pointers wrap naturally. flush has priority
//               over push/pop; a push while full or a pop while empty is
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fifo_entry_t            push_data,
  output fifo_entry_t            head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_COUNT) && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign head    = mem[rd_ptr];

  // Storage write; entries need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch front end. Owns the PC, a single-outstanding
//               req/ack instruction-memory port, a prefetch FIFO and the
//               fetch-to-decode pipeline register. Handles decode stalls,
//               redirects (with FIFO squash) and discarding of fetches made
//               stale by a redirect.
//               Optional macro FETCH_BYPASS_EN: when the FIFO is empty and
//               decode is ready, returning data goes straight into the
//               pipeline register (one cycle less latency).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                 DEPTH     = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_D,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  jump_address,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_plus_two,
  output logic               instr_valid
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [ADDR_W-1:0] stale_addr;
  logic [ADDR_W-1:0] stale_addr_next;
  logic [ADDR_W-1:0] pc_inc;

  logic              redirect;
  logic              fetch_accept;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  fifo_entry_t       fifo_head;
  fifo_entry_t       push_entry;

  // A redirect while decode is stalled is ignored; decode re-presents it.
  assign redirect   = pc_src && !stall_D;
  assign pc_inc     = fetch_pc + ADDR_W'(2);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);

`ifdef FETCH_BYPASS_EN
  assign bypass = fetch_accept && fifo_empty && !stall_D;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = fetch_accept && !bypass;
  assign fifo_pop  = !stall_D && !redirect && !fifo_empty;

  assign push_entry.instr       = imem_rdata;
  assign push_entry.pc_plus_two = pc_inc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (redirect),
    .push_data (push_entry),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Fetch FSM next-state, PC update and memory-port outputs.
  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    stale_addr_next = stale_addr;
    imem_req        = 1'b0;
    imem_addr       = fetch_pc;
    fetch_accept    = 1'b0;
    case (state)
      FETCH: begin
        imem_req  = !fifo_full;
        imem_addr = fetch_pc;
        if (redirect) begin
          fetch_pc_next = jump_address;
          // An unacknowledged request cannot be withdrawn; remember it and
          // wait for its ack. A same-cycle ack is simply dropped.
          if (imem_req && !imem_ack) begin
            stale_addr_next = fetch_pc;
            state_next      = DISCARD;
          end
        end else if (imem_req && imem_ack) begin
          fetch_accept  = 1'b1;
          fetch_pc_next = pc_inc;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = stale_addr;
        if (redirect) begin
          fetch_pc_next = jump_address;
        end
        if (imem_ack) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
    if (reset) begin
      imem_req = 1'b0;
    end
  end

  // Fetch FSM state, PC and stale-address registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      stale_addr <= '0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      stale_addr <= stale_addr_next;
    end
  end

  // Fetch-to-decode pipeline register: bubble on redirect, hold on stall,
  // otherwise take the FIFO head (or bypassed memory data) or a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction <= NOP_INSTR;
      pc_plus_two <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (!stall_D) begin
      if (bypass) begin
        instruction <= imem_rdata;
        pc_plus_two <= pc_inc;
        instr_valid <= 1'b1;
      end else if (!fifo_empty) begin
        instruction <= fifo_head.instr;
        pc_plus_two <= fifo_head.pc_plus_two;
        instr_valid <= 1'b1;
      end else begin
        instruction <= NOP_INSTR;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. The memory returns
//               addr ^ 16'h1111; the reference model predicts the in-order
//               instruction stream (next expected PC, reset by redirects).
//               A second instance checks RESET_PC = 16'hFFFE wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [15:0] NOP = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h1111;
  endfunction

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall_D = 1'b0;
  logic        pc_src = 1'b0;
  logic [15:0] jump_address = 16'h0000;
  logic [15:0] instruction;
  logic [15:0] pc_plus_two;
  logic        instr_valid;

  logic        imem_req2;
  logic [15:0] imem_addr2;
  logic [15:0] rdata2;
  logic [15:0] instruction2;
  logic [15:0] pc_plus_two2;
  logic        valid2;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_pc;

  always #5 clock = ~clock;

  fetch_stage #(
    .DEPTH(2), .RESET_PC(16'h0000), .NOP_INSTR(NOP)
  ) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall_D(stall_D),
    .pc_src(pc_src), .jump_address(jump_address), .instruction(instruction),
    .pc_plus_two(pc_plus_two), .instr_valid(instr_valid)
  );

  assign rdata2 = mem_word(imem_addr2);

  fetch_stage #(
    .DEPTH(2), .RESET_PC(16'hFFFE), .NOP_INSTR(NOP)
  ) dut_wrap (
    .clock(clock), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(1'b1), .imem_rdata(rdata2), .stall_D(1'b0),
    .pc_src(1'b0), .jump_address(16'h0000), .instruction(instruction2),
    .pc_plus_two(pc_plus_two2), .instr_valid(valid2)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Memory response for the current cycle (after combinational settle).
  task automatic drive_mem(input bit ack_en);
    #1;
    imem_ack   = ack_en;
    imem_rdata = imem_req ? mem_word(imem_addr) : 16'hBAD0;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall_D = 1'b0; pc_src = 1'b0; imem_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_D = 1'b0; pc_src = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
    tick();
    n_vec++; if (instruction !== NOP || pc_plus_two !== 16'h0000 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_out got %h/%h/%b want %h/0000/0", instruction, pc_plus_two, instr_valid, NOP);
    end
    imem_ack = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_err++; $display("FAIL rst_first_req got %b/%h want 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    for (int c = 0; c < 8; c++) begin
      drive_mem(1'b1);
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'(2*c)) begin
        n_err++; $display("FAIL zw_addr c=%0d got %b/%h want 1/%h", c, imem_req, imem_addr, 16'(2*c));
      end
      if (c < LAT) begin
        n_vec++; if (instr_valid !== 1'b0 || instruction !== NOP || pc_plus_two !== 16'h0000) begin
          n_err++; $display("FAIL zw_bubble c=%0d got %h/%h/%b want NOP/0000/0", c, instruction, pc_plus_two, instr_valid);
        end
      end else begin
        n_vec++; if (instr_valid !== 1'b1 || instruction !== mem_word(16'(2*(c-LAT))) || pc_plus_two !== 16'(2*(c-LAT)+2)) begin
          n_err++; $display("FAIL zw_out c=%0d got %h/%h/%b want %h/%h/1", c, instruction, pc_plus_two, instr_valid,
                            mem_word(16'(2*(c-LAT))), 16'(2*(c-LAT)+2));
        end
      end
      tick();
    end
    exp_pc = 16'(2*(8-LAT));
  endtask

  task automatic test_stall();
    logic [15:0] hi, hp;
    logic        hv;
    n_vec++; if (instr_valid !== 1'b1 || instruction !== mem_word(exp_pc)) begin
      n_err++; $display("FAIL stall_pre got %h/%b want %h/1", instruction, instr_valid, mem_word(exp_pc));
    end
    hi = instruction; hp = pc_plus_two; hv = instr_valid;
    exp_pc = exp_pc + 16'd2;
    stall_D = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_mem(1'b1);
      tick();
      n_vec++; if (instruction !== hi || pc_plus_two !== hp || instr_valid !== hv) begin
        n_err++; $display("FAIL stall_hold c=%0d got %h/%h/%b want %h/%h/%b", c, instruction, pc_plus_two, instr_valid, hi, hp, hv);
      end
    end
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_full_req got %b want 0", imem_req); end
    stall_D = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive_mem(1'b1);
      tick();
      n_vec++; if (instr_valid !== 1'b1 || instruction !== mem_word(exp_pc) || pc_plus_two !== exp_pc + 16'd2) begin
        n_err++; $display("FAIL stall_drain c=%0d got %h/%h/%b want %h/%h/1", c, instruction, pc_plus_two, instr_valid,
                          mem_word(exp_pc), exp_pc + 16'd2);
      end
      exp_pc = exp_pc + 16'd2;
    end
  endtask

  task automatic test_redirect_discard();
    bit found = 1'b0;
    do_reset();
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (imem_req && imem_addr == 16'h0008) found = 1'b1;
      else begin drive_mem(1'b1); tick(); end
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL rd_setup got addr %h want 0008", imem_addr); end
    imem_ack = 1'b0; pc_src = 1'b1; jump_address = 16'h0100;
    tick();
    pc_src = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008 || instr_valid !== 1'b0) begin
        n_err++; $display("FAIL rd_discard c=%0d got %b/%h/%b want 1/0008/0", c, imem_req, imem_addr, instr_valid);
      end
      imem_ack = (c == 2); imem_rdata = 16'hDEAD;
      tick();
    end
    for (int c = 0; c <= LAT + 1; c++) begin
      drive_mem(1'b1);
      if (c == 0) begin
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
          n_err++; $display("FAIL rd_target got %b/%h want 1/0100", imem_req, imem_addr);
        end
      end
      if (c < LAT) begin
        n_vec++; if (instr_valid !== 1'b0 || instruction !== NOP) begin
          n_err++; $display("FAIL rd_bubble c=%0d got %h/%b want NOP/0", c, instruction, instr_valid);
        end
      end else begin
        n_vec++; if (instr_valid !== 1'b1 || instruction !== mem_word(16'(16'h0100 + 2*(c-LAT))) ||
                     pc_plus_two !== 16'(16'h0102 + 2*(c-LAT))) begin
          n_err++; $display("FAIL rd_out c=%0d got %h/%h/%b want %h/%h/1", c, instruction, pc_plus_two, instr_valid,
                            mem_word(16'(16'h0100 + 2*(c-LAT))), 16'(16'h0102 + 2*(c-LAT)));
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_stall();
    logic [15:0] hi, hp;
    logic        hv;
    hi = instruction; hp = pc_plus_two; hv = instr_valid;
    stall_D = 1'b1; pc_src = 1'b1; jump_address = 16'h0200;
    for (int c = 0; c < 2; c++) begin
      drive_mem(1'b1);
      n_vec++; if (imem_addr === 16'h0200) begin n_err++; $display("FAIL rs_early addr %h want not 0200", imem_addr); end
      tick();
      n_vec++; if (instruction !== hi || pc_plus_two !== hp || instr_valid !== hv) begin
        n_err++; $display("FAIL rs_hold c=%0d got %h/%h/%b want %h/%h/%b", c, instruction, pc_plus_two, instr_valid, hi, hp, hv);
      end
    end
    stall_D = 1'b0;
    drive_mem(1'b1);
    tick();
    pc_src = 1'b0;
    for (int c = 0; c <= LAT; c++) begin
      drive_mem(1'b1);
      if (c == 0) begin
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
          n_err++; $display("FAIL rs_target got %b/%h want 1/0200", imem_req, imem_addr);
        end
      end
      if (c < LAT) begin
        n_vec++; if (instr_valid !== 1'b0 || instruction !== NOP) begin
          n_err++; $display("FAIL rs_bubble c=%0d got %h/%b want NOP/0", c, instruction, instr_valid);
        end
      end else begin
        n_vec++; if (instr_valid !== 1'b1 || instruction !== mem_word(16'h0200) || pc_plus_two !== 16'h0202) begin
          n_err++; $display("FAIL rs_out got %h/%h/%b want %h/0202/1", instruction, pc_plus_two, instr_valid, mem_word(16'h0200));
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c <= LAT; c++) begin
      #1;
      if (c == 0) begin
        n_vec++; if (imem_req2 !== 1'b1 || imem_addr2 !== 16'hFFFE) begin
          n_err++; $display("FAIL wrap_first got %b/%h want 1/FFFE", imem_req2, imem_addr2);
        end
      end
      if (c == 1) begin
        n_vec++; if (imem_addr2 !== 16'h0000) begin n_err++; $display("FAIL wrap_second got %h want 0000", imem_addr2); end
      end
      if (c == LAT) begin
        n_vec++; if (valid2 !== 1'b1 || instruction2 !== mem_word(16'hFFFE) || pc_plus_two2 !== 16'h0000) begin
          n_err++; $display("FAIL wrap_out got %h/%h/%b want %h/0000/1", instruction2, pc_plus_two2, valid2, mem_word(16'hFFFE));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midtx();
    do_reset();
    drive_mem(1'b1); tick();
    drive_mem(1'b1); tick();
    drive_mem(1'b0); tick();
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rm_pending got %b want 1", imem_req); end
    reset = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rm_req_in_reset got %b want 0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    reset = 1'b0; imem_ack = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0 ||
                 instruction !== NOP || pc_plus_two !== 16'h0000) begin
      n_err++; $display("FAIL rm_after got %b/%h/%h/%h/%b want 1/0000/NOP/0000/0", imem_req, imem_addr,
                        instruction, pc_plus_two, instr_valid);
    end
    for (int c = 0; c <= LAT; c++) begin
      drive_mem(1'b1);
      if (c == LAT) begin
        n_vec++; if (instr_valid !== 1'b1 || instruction !== mem_word(16'h0000) || pc_plus_two !== 16'h0002) begin
          n_err++; $display("FAIL rm_restart got %h/%h/%b want %h/0002/1", instruction, pc_plus_two, instr_valid, mem_word(16'h0000));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] p_instr, p_pc2, p_addr, p_jump;
    logic        p_valid, p_req, p_ack, p_stall, p_redir;
    int          n_valid = 0;
    do_reset();
    exp_pc = 16'h0000;
    for (int k = 0; k < 600; k++) begin
      stall_D      = ($urandom_range(0, 3) == 0);
      pc_src       = ($urandom_range(0, 11) == 0);
      jump_address = 16'($urandom) & 16'hFFFE;
      #1;
      imem_ack   = ($urandom_range(0, 9) < 6);
      imem_rdata = imem_req ? mem_word(imem_addr) : 16'($urandom);
      p_instr = instruction; p_pc2 = pc_plus_two; p_valid = instr_valid;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_stall = stall_D; p_redir = pc_src && !stall_D; p_jump = jump_address;
      tick();
      #1;
      if (p_stall) begin
        n_vec++; if (instruction !== p_instr || pc_plus_two !== p_pc2 || instr_valid !== p_valid) begin
          n_err++; $display("FAIL rnd_hold k=%0d got %h/%h/%b want %h/%h/%b", k, instruction, pc_plus_two, instr_valid,
                            p_instr, p_pc2, p_valid);
        end
      end else if (p_redir) begin
        n_vec++; if (instr_valid !== 1'b0 || instruction !== NOP) begin
          n_err++; $display("FAIL rnd_squash k=%0d got %h/%b want NOP/0", k, instruction, instr_valid);
        end
      end else if (instr_valid === 1'b1) begin
        n_vec++; if (instruction !== mem_word(exp_pc) || pc_plus_two !== exp_pc + 16'd2) begin
          n_err++; $display("FAIL rnd_stream k=%0d got %h/%h want %h/%h", k, instruction, pc_plus_two,
                            mem_word(exp_pc), exp_pc + 16'd2);
        end
        exp_pc = exp_pc + 16'd2;
        n_valid++;
      end else begin
        n_vec++; if (instruction !== NOP) begin n_err++; $display("FAIL rnd_nop k=%0d got %h want NOP", k, instruction); end
      end
      if (p_redir) exp_pc = p_jump;
      if (p_req && !p_ack) begin
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          n_err++; $display("FAIL rnd_req_hold k=%0d got %b/%h want 1/%h", k, imem_req, imem_addr, p_addr);
        end
      end
    end
    n_vec++; if (n_valid < 100) begin n_err++; $display("FAIL rnd_progress got %0d want >=100", n_valid); end
    stall_D = 1'b0; pc_src = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_discard();
    test_redirect_stall();
    test_wrap();
    test_reset_midtx();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 16-bit pipeline.
- Produces `instruction` / `pc_plus_two` for the decode stage and consumes decode's `pc_src` / `jump_address` redirect.
- Owns the PC, a req/ack instruction-memory port (one outstanding request), a small prefetch FIFO and the fetch-to-decode pipeline register.
- Handles stalls, redirects with squash, and discarding stale in-flight fetches.

Parameters:
- DEPTH, 2, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_INSTR, 16'h0000, instruction driven to decode when no valid instruction is present.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until the ack cycle.
- imem_addr  out  16  fetch byte address; stable while imem_req=1 and no ack.
- imem_ack  in  1  transaction completes in a cycle with imem_req&&imem_ack; same-cycle (zero-wait) ack allowed.
- imem_rdata  in  16  instruction word; valid when imem_ack=1.
- stall_D  in  1  decode hold; pipeline register keeps its value.
- pc_src  in  1  decode requests redirect.
- jump_address  in  16  redirect target.
- instruction  out  16  to decode.
- pc_plus_two  out  16  fetched-instruction PC + 2, mod 2^16.
- instr_valid  out  1  1 = instruction is real, 0 = bubble (NOP_INSTR).

Behaviour:
- Reset (any cycle, including mid-transaction):
  - fetch_pc=RESET_PC, FIFO emptied, state=FETCH.
  - instruction=NOP_INSTR, pc_plus_two=16'h0000, instr_valid=0.
  - imem_req=0 during the reset cycle. The memory tolerates abandoned requests.
- FSM states:
  - FETCH: imem_req = (count < DEPTH), imem_addr = fetch_pc.
    - On req&&ack: push {imem_rdata, fetch_pc+2} into the FIFO; fetch_pc += 2, wrapping 16'hFFFE -> 16'h0000.
  - DISCARD: imem_req=1, imem_addr=stale_addr. On ack, the data is dropped and the state returns to FETCH.
- Redirect is accepted only when pc_src && !stall_D:
  - fetch_pc <= jump_address; FIFO flushed; pipeline register loads the bubble.
  - If imem_req=1 and imem_ack=0 in that cycle: stale_addr <= imem_addr, state -> DISCARD.
  - If ack arrives in the same cycle as the redirect, its data is dropped and the state stays FETCH.
- Pipeline register:
  - If !stall_D and no redirect: pop the FIFO head into instruction/pc_plus_two with instr_valid=1.
  - If the FIFO is empty in that case: load NOP_INSTR with instr_valid=0; pc_plus_two holds its value.
  - If stall_D: all outputs hold. The FIFO keeps filling until full.
- FIFO:
  - Pushes only occur when count < DEPTH, so there is no overflow.
  - Push and pop in the same cycle are legal; count is unchanged.
- Latency (zero-wait memory, no stall): ack in cycle N gives the instruction on the outputs in cycle N+2.
- Throughput: one instruction per cycle once the FIFO has primed.
- Accepted redirect in cycle N: first request to jump_address is in cycle N+1, or one cycle after the stale ack if in DISCARD.
- Exactly one request is ever outstanding.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Enabled: when the FIFO is empty, !stall_D, no redirect and req&&ack, imem_rdata loads the pipeline register directly and the FIFO is not pushed. Ack N gives output N+1.
- Disabled: all data passes through the FIFO; latency is 2 as above.
- Redirect, discard and stall rules are identical in both builds.

Decomposition:
- Package fetch_pkg holds:
  - the state enum {FETCH, DISCARD};
  - the constants INSTR_W=16, ADDR_W=16, default NOP_INSTR and RESET_PC;
  - the FIFO entry struct {instr, pc_plus_two}.
- Sub-module fetch_fifo: parameterised DEPTH.
  - Ports: push, pop, flush, count, head data.
  - Synchronous active-high reset.

Test Plan:
- Reset release, zero-wait memory: imem_addr 0x0000, 0x0002, 0x0004 on consecutive cycles. Outputs 0x1111/pc_plus_two 0x0002 appear two cycles after the first ack, then one instruction per cycle.
- stall_D held 5 cycles: outputs frozen. Requests stop once count=DEPTH (imem_req=0). On release, FIFO entries drain in order with no loss or duplication.
- Redirect to 0x0100 while a request to 0x0008 is pending with ack delayed 3 cycles: the 0x0008 data is dropped. The next request is 0x0100, and instr_valid is 0 until 0x0100's instruction arrives.
- Redirect coinciding with stall_D=1: ignored. Redirect accepted on the first unstalled cycle.
- RESET_PC=16'hFFFE: pc_plus_two=0x0000 and the second fetch address is 0x0000.
- reset asserted during the wait for an ack: imem_req=0 in the reset cycle. Afterwards, outputs are NOP/valid 0 and fetching restarts at RESET_PC. A late ack for the old request while req=0 is ignored.
